// File: rtl/fill_readout_pkg.sv
// Shared types and constants for the fill readout state machine.
// Optional checksum checking is enabled by defining FILL_READOUT_CHECKSUM_CHECK_EN.
package fill_readout_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL_HDR = 3'd1,
        WFM_HDR  = 3'd2,
        DATA     = 3'd3,
        CHECKSUM = 3'd4,
        DONE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TYPE_FILL_HDR = 2'd0,
        TYPE_WFM_HDR  = 2'd1,
        TYPE_ADC      = 2'd2,
        TYPE_CHECKSUM = 2'd3
    } out_type_t;

    localparam int WFM_CNT_LSB   = 0;
    localparam int WFM_CNT_MSB   = 15;
    localparam int BURST_CNT_LSB = 16;
    localparam int BURST_CNT_MSB = 39;
    localparam int WFM_CNT_W     = WFM_CNT_MSB - WFM_CNT_LSB + 1;
    localparam int BURST_CNT_W   = BURST_CNT_MSB - BURST_CNT_LSB + 1;

    localparam int CHECKSUM_W = 32;
    localparam int ACC_LANES  = 4;
    localparam int ACC_WORD_W = ACC_LANES * CHECKSUM_W;

    function automatic out_type_t type_for_state(input state_t s);
        case (s)
            FILL_HDR: return TYPE_FILL_HDR;
            WFM_HDR:  return TYPE_WFM_HDR;
            DATA:     return TYPE_ADC;
            CHECKSUM: return TYPE_CHECKSUM;
            default:  return TYPE_FILL_HDR;
        endcase
    endfunction

endpackage

// File: rtl/fill_readout_sm_if.sv
// Input and output word streams of the fill readout state machine.
// Used identically whether or not FILL_READOUT_CHECKSUM_CHECK_EN is defined.
interface fill_readout_sm_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_type;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_type, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_type, out_valid
    );
endinterface

// File: rtl/fill_checksum_acc.sv
// Running modulo-2^32 sum of the four 32-bit lanes of each ADC burst word.
// Only instantiated when FILL_READOUT_CHECKSUM_CHECK_EN is defined.
module fill_checksum_acc
    import fill_readout_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  add_en,
    input  logic [ACC_WORD_W-1:0] word,
    output logic [CHECKSUM_W-1:0] sum
);

    logic [CHECKSUM_W-1:0] lane [ACC_LANES];
    logic [CHECKSUM_W-1:0] word_sum;
    logic [CHECKSUM_W-1:0] sum_q;
    logic [CHECKSUM_W-1:0] sum_d;

    genvar gi;
    generate
        for (gi = 0; gi < ACC_LANES; gi++) begin : g_lane
            assign lane[gi] = word[gi*CHECKSUM_W +: CHECKSUM_W];
        end
    endgenerate

    always_comb begin
        word_sum = '0;
        for (int i = 0; i < ACC_LANES; i++) begin
            word_sum = word_sum + lane[i];
        end
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (add_en) begin
            sum_d = sum_q + word_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/fill_readout_sm.sv
// Parses stored fills (header, waveform headers, ADC bursts, checksum) and forwards them typed.
// Define FILL_READOUT_CHECKSUM_CHECK_EN to accumulate and verify the fill checksum.
module fill_readout_sm
    import fill_readout_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_enable,
    input  logic              rd_abort,
    fill_readout_sm_if.slave  bus,
    output logic              fill_done,
    output logic              hdr_err,
    output logic              checksum_err,
    output logic              sm_idle
);

    state_t state_q, state_d;

    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic [1:0]             out_type_q, out_type_d;
    logic                   out_valid_q, out_valid_d;
    logic [WFM_CNT_W-1:0]   wfm_cnt_q, wfm_cnt_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [BURST_CNT_W-1:0] burst_len_q, burst_len_d;
    logic                   fill_done_q, fill_done_d;
    logic                   hdr_err_q, hdr_err_d;
    logic                   cks_err_q, cks_err_d;

    logic                   active;
    logic                   in_ready_c;
    logic                   accept;
    logic                   cks_mismatch;
    logic [WFM_CNT_W-1:0]   hdr_wfm;
    logic [BURST_CNT_W-1:0] hdr_burst;

    assign hdr_wfm   = bus.in_data[WFM_CNT_MSB:WFM_CNT_LSB];
    assign hdr_burst = bus.in_data[BURST_CNT_MSB:BURST_CNT_LSB];

    // Abort blocks the handshake so a word presented in the abort cycle stays upstream.
    assign active     = (state_q == FILL_HDR) || (state_q == WFM_HDR) ||
                        (state_q == DATA)     || (state_q == CHECKSUM);
    assign in_ready_c = active && (!out_valid_q || bus.out_ready) && !rd_abort;
    assign accept     = in_ready_c && bus.in_valid;

`ifdef FILL_READOUT_CHECKSUM_CHECK_EN
    logic                  acc_clr;
    logic                  acc_add;
    logic [CHECKSUM_W-1:0] acc_sum;

    assign acc_clr = rd_abort || ((state_q == FILL_HDR) && accept);
    assign acc_add = (state_q == DATA) && accept;

    fill_checksum_acc u_checksum_acc (
        .clk    (clk),
        .rst_n  (reset_n),
        .clr    (acc_clr),
        .add_en (acc_add),
        .word   (bus.in_data[ACC_WORD_W-1:0]),
        .sum    (acc_sum)
    );

    assign cks_mismatch = (acc_sum != bus.in_data[CHECKSUM_W-1:0]);
`else
    assign cks_mismatch = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_type_d  = out_type_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        wfm_cnt_d   = wfm_cnt_q;
        burst_cnt_d = burst_cnt_q;
        burst_len_d = burst_len_q;
        fill_done_d = 1'b0;
        hdr_err_d   = 1'b0;
        cks_err_d   = 1'b0;

        if (accept) begin
            out_data_d  = bus.in_data;
            out_type_d  = type_for_state(state_q);
            out_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rd_enable) begin
                    state_d = FILL_HDR;
                end
            end
            FILL_HDR: begin
                if (accept) begin
                    wfm_cnt_d   = hdr_wfm;
                    burst_len_d = hdr_burst;
                    if ((hdr_wfm == '0) || (hdr_burst == '0)) begin
                        hdr_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = WFM_HDR;
                    end
                end
            end
            WFM_HDR: begin
                if (accept) begin
                    burst_cnt_d = burst_len_q;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    burst_cnt_d = burst_cnt_q - 1'b1;
                    if (burst_cnt_q == BURST_CNT_W'(1)) begin
                        wfm_cnt_d = wfm_cnt_q - 1'b1;
                        state_d   = (wfm_cnt_q == WFM_CNT_W'(1)) ? CHECKSUM : WFM_HDR;
                    end
                end
            end
            CHECKSUM: begin
                if (accept) begin
                    fill_done_d = 1'b1;
                    cks_err_d   = cks_mismatch;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rd_abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            wfm_cnt_d   = '0;
            burst_cnt_d = '0;
            burst_len_d = '0;
            fill_done_d = 1'b0;
            hdr_err_d   = 1'b0;
            cks_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_type_q  <= '0;
            out_valid_q <= 1'b0;
            wfm_cnt_q   <= '0;
            burst_cnt_q <= '0;
            burst_len_q <= '0;
            fill_done_q <= 1'b0;
            hdr_err_q   <= 1'b0;
            cks_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_type_q  <= out_type_d;
            out_valid_q <= out_valid_d;
            wfm_cnt_q   <= wfm_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            burst_len_q <= burst_len_d;
            fill_done_q <= fill_done_d;
            hdr_err_q   <= hdr_err_d;
            cks_err_q   <= cks_err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_type  = out_type_q;
    assign bus.out_valid = out_valid_q;
    assign fill_done     = fill_done_q;
    assign hdr_err       = hdr_err_q;
    assign checksum_err  = cks_err_q;
    assign sm_idle       = (state_q == IDLE);

endmodule

// File: tb/tb_fill_readout_sm.sv
// Directed self-checking bench for fill_readout_sm; expected checksum_err follows
// whether FILL_READOUT_CHECKSUM_CHECK_EN is defined for the build.
module tb_fill_readout_sm;

`ifdef FILL_READOUT_CHECKSUM_CHECK_EN
    localparam int EXP_CERR = 1;
`else
    localparam int EXP_CERR = 0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic rd_enable;
    logic rd_abort;
    logic fill_done;
    logic hdr_err;
    logic checksum_err;
    logic sm_idle;
    logic stim_done;

    int n_checks = 0;
    int n_fail   = 0;

    fill_readout_sm_if #(.DATA_W(128)) bus ();

    fill_readout_sm #(.DATA_W(128)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rd_enable    (rd_enable),
        .rd_abort     (rd_abort),
        .bus          (bus.slave),
        .fill_done    (fill_done),
        .hdr_err      (hdr_err),
        .checksum_err (checksum_err),
        .sm_idle      (sm_idle)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    logic [127:0] obs_data [$];
    logic [1:0]   obs_type [$];
    int           cyc          = 0;
    int           n_done       = 0;
    int           n_herr       = 0;
    int           n_cerr       = 0;
    int           last_done    = -1;
    int           last_cerr    = -2;
    int           stall_events = 0;
    int           stall_bad    = 0;
    logic         prev_stall   = 1'b0;
    logic [127:0] held_data    = '0;
    logic [1:0]   held_type    = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            obs_data.push_back(bus.out_data);
            obs_type.push_back(bus.out_type);
            $display("xfer cyc=%0d type=%0d data=%032h", cyc, bus.out_type, bus.out_data);
        end
        if (fill_done) begin
            n_done    <= n_done + 1;
            last_done <= cyc;
        end
        if (hdr_err)      n_herr <= n_herr + 1;
        if (checksum_err) begin
            n_cerr    <= n_cerr + 1;
            last_cerr <= cyc;
        end
        if (prev_stall && bus.out_valid) begin
            stall_events <= stall_events + 1;
            if (bus.out_data !== held_data || bus.out_type !== held_type)
                stall_bad <= stall_bad + 1;
        end
        prev_stall <= bus.out_valid && !bus.out_ready;
        held_data  <= bus.out_data;
        held_type  <= bus.out_type;
    end

    logic [127:0] exp_data [$];
    logic [1:0]   exp_type [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] make_hdr(input int w, input int b);
        logic [23:0] b24;
        logic [15:0] w16;
        b24 = 24'(b);
        w16 = 16'(w);
        return {64'hDEAD_BEEF_0BAD_F00D, 24'h000000, b24, w16};
    endfunction

    function automatic logic [127:0] wfm_hdr(input int wf);
        return {32'h5746_4D00, 64'h0, 32'h0000_AA00 + 32'(wf)};
    endfunction

    function automatic logic [127:0] burst_word(input int wf, input int n);
        logic [31:0] a;
        a = 32'hF000_0000 + 32'(wf * 16 + n);
        return {a * 32'd3, 32'h8000_0001 + 32'(n), ~a, 32'h1234_0000 | 32'(n)};
    endfunction

    function automatic logic [31:0] lane_sum(input logic [127:0] w);
        return w[31:0] + w[63:32] + w[95:64] + w[127:96];
    endfunction

    task automatic send_word(input logic [127:0] w, input logic [1:0] t);
        int waited;
        bit ok;
        waited = 0;
        ok = 1'b0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        exp_data.push_back(w);
        exp_type.push_back(t);
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else waited++;
        end
        if (!ok) chk("accept_timeout", 128'(ok), 128'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_fill(input int w, input int b, input logic [31:0] corrupt);
        logic [31:0]  sum;
        logic [127:0] word;
        sum = '0;
        rd_enable = 1'b1;
        send_word(make_hdr(w, b), 2'd0);
        rd_enable = 1'b0;
        for (int wf = 0; wf < w; wf++) begin
            send_word(wfm_hdr(wf), 2'd1);
            for (int n = 0; n < b; n++) begin
                word = burst_word(wf, n);
                sum  = sum + lane_sum(word);
                send_word(word, 2'd2);
            end
        end
        send_word({96'hC5C5_C5C5_0000_0000_1111_2222, sum + corrupt}, 2'd3);
    endtask

    task automatic check_words(input string tag, input int base);
        chk($sformatf("%s_count", tag), 128'(obs_data.size() - base), 128'(exp_data.size()));
        for (int i = 0; i < exp_data.size(); i++) begin
            if (base + i < obs_data.size()) begin
                chk($sformatf("%s_data%0d", tag, i), obs_data[base+i], exp_data[i]);
                chk($sformatf("%s_type%0d", tag, i), 128'(obs_type[base+i]), 128'(exp_type[i]));
            end
        end
        exp_data.delete();
        exp_type.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int d0;
        int c0;
        int h0;
        int s0;
        int sb0;

        reset_n      = 1'b1;
        rd_enable    = 1'b0;
        rd_abort     = 1'b0;
        stim_done    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_sm_idle",   128'(sm_idle),       128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_in_ready",  128'(bus.in_ready),  128'd0);
        chk("rst_out_data",  bus.out_data,        128'd0);
        chk("rst_out_type",  128'(bus.out_type),  128'd0);
        chk("rst_pulses",    128'({fill_done, hdr_err, checksum_err}), 128'd0);
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(2);
        chk("post_rst_idle", 128'(sm_idle), 128'd1);

        // Nominal fill W=2 B=3
        base = obs_data.size(); d0 = n_done; c0 = n_cerr;
        run_fill(2, 3, 32'd0);
        wait_cycles(3);
        check_words("nominal", base);
        chk("nominal_done", 128'(n_done - d0), 128'd1);
        chk("nominal_cerr", 128'(n_cerr - c0), 128'd0);
        chk("nominal_idle", 128'(sm_idle), 128'd1);

        // Corrupted checksum
        base = obs_data.size(); d0 = n_done; c0 = n_cerr;
        run_fill(2, 3, 32'd1);
        wait_cycles(3);
        check_words("badcks", base);
        chk("badcks_done", 128'(n_done - d0), 128'd1);
        chk("badcks_cerr", 128'(n_cerr - c0), 128'(EXP_CERR));
`ifdef FILL_READOUT_CHECKSUM_CHECK_EN
        chk("badcks_same_cycle", 128'(last_cerr), 128'(last_done));
`endif

        // Header with zero waveform count
        base = obs_data.size(); d0 = n_done; h0 = n_herr;
        rd_enable = 1'b1;
        send_word(make_hdr(0, 5), 2'd0);
        rd_enable = 1'b0;
        chk("zhdr_err_pulse",  128'(hdr_err),  128'd1);
        chk("zhdr_done_state", 128'(sm_idle),  128'd0);
        wait_cycles(1);
        chk("zhdr_idle",     128'(sm_idle), 128'd1);
        chk("zhdr_err_low",  128'(hdr_err), 128'd0);
        bus.in_data  = burst_word(0, 0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("zhdr_no_accept%0d", i), 128'(bus.in_ready), 128'd0);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_cycles(1);
        check_words("zhdr", base);
        chk("zhdr_err_count", 128'(n_herr - h0), 128'd1);
        chk("zhdr_no_done",   128'(n_done - d0), 128'd0);

        // Backpressure toggling every cycle, W=1 B=4
        base = obs_data.size(); d0 = n_done; s0 = stall_events; sb0 = stall_bad;
        stim_done = 1'b0;
        fork
            begin
                run_fill(1, 4, 32'd0);
                stim_done = 1'b1;
            end
            begin
                int g;
                g = 0;
                while (!stim_done && g < 2000) begin
                    @(posedge clk);
                    #1 bus.out_ready = ~bus.out_ready;
                    g++;
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_cycles(4);
        check_words("stall", base);
        chk("stall_done",   128'(n_done - d0), 128'd1);
        chk("stall_stable", 128'(stall_bad - sb0), 128'd0);
        chk("stall_seen",   128'((stall_events - s0) > 0), 128'd1);

        // Abort during second DATA word
        base = obs_data.size(); d0 = n_done;
        rd_enable = 1'b1;
        send_word(make_hdr(2, 3), 2'd0);
        rd_enable = 1'b0;
        send_word(wfm_hdr(0), 2'd1);
        send_word(burst_word(0, 0), 2'd2);
        bus.in_data  = burst_word(0, 1);
        bus.in_valid = 1'b1;
        rd_abort     = 1'b1;
        @(posedge clk);
        #1;
        rd_abort     = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_idle",      128'(sm_idle),       128'd1);
        chk("abort_out_valid", 128'(bus.out_valid), 128'd0);
        wait_cycles(4);
        check_words("abort", base);
        chk("abort_no_done",  128'(n_done - d0), 128'd0);
        chk("abort_in_ready", 128'(bus.in_ready), 128'd0);

        // Asynchronous reset mid-DATA, then a W=1 B=1 fill
        base = obs_data.size();
        rd_enable = 1'b1;
        send_word(make_hdr(1, 2), 2'd0);
        rd_enable = 1'b0;
        send_word(wfm_hdr(0), 2'd1);
        send_word(burst_word(0, 0), 2'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("arst_out_data",  bus.out_data,        128'd0);
        chk("arst_out_type",  128'(bus.out_type),  128'd0);
        chk("arst_sm_idle",   128'(sm_idle),       128'd1);
        chk("arst_in_ready",  128'(bus.in_ready),  128'd0);
        #3 reset_n = 1'b1;
        void'(exp_data.pop_back());
        void'(exp_type.pop_back());
        wait_cycles(1);
        check_words("arst_pre", base);
        base = obs_data.size(); d0 = n_done; c0 = n_cerr;
        run_fill(1, 1, 32'd0);
        wait_cycles(3);
        check_words("arst_post", base);
        chk("arst_post_done", 128'(n_done - d0), 128'd1);
        chk("arst_post_cerr", 128'(n_cerr - c0), 128'd0);
        chk("arst_post_idle", 128'(sm_idle), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fill_readout_sm.md
FILL_READOUT_SM -- requirements
Module: fill_readout_sm

Interface
REQ-001 SHALL have parameter DATA_W, default 128, width of stored fill words.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rd_enable  in  1  readout mode enabled; sampled only in IDLE.
- rd_abort  in  1  synchronous abort of the current fill.
- in_data  in  DATA_W  stored fill word from DDR3 read FIFO.
- in_valid  in  1  in_data valid.
- in_ready  out  1  word accepted when in_valid && in_ready.
- out_data  out  DATA_W  forwarded word.
- out_type  out  2  0 fill header, 1 waveform header, 2 ADC burst, 3 checksum.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- fill_done  out  1  one-cycle pulse after the checksum word is accepted.
- hdr_err  out  1  one-cycle pulse when a fill header has zero waveform or zero burst count.
- checksum_err  out  1  one-cycle pulse on checksum mismatch.
- sm_idle  out  1  high in IDLE (front-panel LED).

Function
REQ-003 Fill word order SHALL be: fill header; then per waveform one waveform header and B burst words; then one checksum word.
REQ-004 Fill header fields SHALL be: [15:0] waveform count W; [39:16] burst count B.
REQ-005 States SHALL be IDLE, FILL_HDR, WFM_HDR, DATA, CHECKSUM, DONE.
REQ-006 IDLE -> FILL_HDR when rd_enable=1; otherwise stay in IDLE.
REQ-007 On FILL_HDR accept: latch W and B.
- If W=0 or B=0: pulse hdr_err and go to DONE.
- Otherwise go to WFM_HDR.
REQ-008 On WFM_HDR accept: load burst counter with B, then go to DATA.
REQ-009 DATA SHALL decrement the burst counter on each accept. On the accept at count 1, decrement the waveform counter and go to WFM_HDR, or to CHECKSUM if that was the last waveform.
REQ-010 On CHECKSUM accept: pulse fill_done and go to DONE. DONE -> IDLE unconditionally after one cycle.
REQ-011 Checksum SHALL be the modulo-2^32 sum of the four 32-bit lanes of every ADC burst word. It clears on fill-header accept. Comparison is against checksum word bits [31:0].
REQ-012 Output stage SHALL be one register.
- in_ready = (state in FILL_HDR..CHECKSUM) && (!out_valid || out_ready).
- Latency is 1 cycle from accept to out_valid.
REQ-013 out_data/out_type SHALL hold while out_valid && !out_ready.
REQ-014 Counters SHALL be 16-bit (waveforms) and 24-bit (bursts). They never wrap, because zero counts are rejected per REQ-007.
REQ-015 rd_abort=1 SHALL force IDLE next cycle, clear out_valid and counters, and suppress all pulses in that cycle. It has priority over any simultaneous accept.
REQ-016 rd_enable deassertion mid-fill SHALL be ignored; the fill completes.
REQ-017 Words SHALL NOT be accepted in IDLE or DONE (in_ready=0).

Reset
REQ-018 Assertion of reset_n=0 SHALL asynchronously force:
- state IDLE;
- out_valid, fill_done, hdr_err, checksum_err = 0;
- out_data, out_type = 0;
- counters and checksum accumulator = 0;
- sm_idle = 1.
REQ-019 Deassertion SHALL take effect on the first clk edge after reset_n=1.

Configuration
REQ-020 With macro FILL_READOUT_CHECKSUM_CHECK_EN defined, the checksum SHALL be accumulated and compared, and checksum_err pulses in the CHECKSUM accept cycle on mismatch.
REQ-021 Without it, the accumulator SHALL be absent, checksum_err is tied 0, and the checksum word is forwarded unchecked.

Structure
REQ-022 Package fill_readout_pkg SHALL hold:
- the state enum;
- out_type codes;
- header field LSB/MSB constants (WFM_CNT, BURST_CNT);
- CHECKSUM_W=32.
REQ-023 Sub-module fill_checksum_acc (clear, add-enable, 128-bit word in, 32-bit sum out) SHALL be instantiated only under FILL_READOUT_CHECKSUM_CHECK_EN.

Verification
REQ-024 Nominal fill: W=2, B=3, out_ready=1, correct checksum -> 10 words out with types 0,1,2,2,2,1,2,2,2,3; fill_done once; checksum_err=0.
REQ-025 Corrupted checksum (sum+1) -> all 10 words forwarded; checksum_err and fill_done pulse the same cycle.
REQ-026 Header with W=0, B=5 -> hdr_err pulse; header forwarded with type 0; IDLE two cycles later; no further accepts.
REQ-027 out_ready toggling 1/0 every cycle with W=1, B=4 -> no word lost or duplicated; out_data stable while stalled.
REQ-028 rd_abort asserted during second DATA word with in_valid=1 -> that word not accepted; IDLE next cycle; out_valid=0; no fill_done.
REQ-029 reset_n pulsed low mid-DATA between clock edges -> outputs reach reset values immediately; next fill with W=1, B=1 completes normally.
